// File: rtl/vga_pixel_fetch.sv
// Upscaling pixel fetch: framebuffer address generation, palette lookup, strobe alignment and
// tear-free buffer swaps. Optional `BORDER_COLOR_EN adds a border_rgb override on the edge pixels.
module vga_pixel_fetch #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic [9:0]        vgaX,
  input  logic [9:0]        vgaY,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_b_in,
  input  logic              sync_b_in,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [IDX_W-1:0]  fb_rdata,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_idx,
  input  logic [23:0]       pal_data,
`ifdef BORDER_COLOR_EN
  input  logic [23:0]       border_rgb,
`endif
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              back_sel,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_b,
  output logic              sync_b
);

  localparam int unsigned FbW    = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned FbH    = V_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned FbSize = FbW * FbH;
  localparam int unsigned NPal   = 1 << IDX_W;
  localparam logic [9:0]  HLast  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  VLast  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VStart = 10'(V_ACTIVE);

  // Stage 1 state
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              act1_q, act1_d;
  // Stage 2 / 3 state
  logic              act2_q;
  logic [23:0]       rgb_q, rgb_d;
  // Strobe delay lines, oldest bit is the output
  logic [2:0]        hs_q, vs_q, bl_q, sy_q;
  // Buffer swap state
  logic              front_sel_q, front_sel_d;
  logic              swap_ack_q, swap_ack_d;
  logic [23:0]       pal_q [NPal];

  logic [9:0]        x_c, y_c, col, row;
  logic              in_x, in_y;

`ifdef BORDER_COLOR_EN
  logic              border1_q, border1_d, border2_q;
  logic [23:0]       brgb1_q, brgb2_q;
`endif

  // Stage 1: clamp coordinates so the address never leaves the two buffers during blanking.
  always_comb begin
    in_x      = 32'(vgaX) < H_ACTIVE;
    in_y      = 32'(vgaY) < V_ACTIVE;
    x_c       = in_x ? vgaX : HLast;
    y_c       = in_y ? vgaY : VLast;
    col       = x_c >> SCALE_SHIFT;
    row       = y_c >> SCALE_SHIFT;
    act1_d    = in_x && in_y;
    fb_addr_d = ADDR_W'((front_sel_q ? FbSize : 32'd0) + 32'(row) * FbW + 32'(col));
  end

`ifdef BORDER_COLOR_EN
  always_comb begin
    border1_d = act1_d && ((32'(col) == 0) || (32'(col) == FbW - 1) ||
                           (32'(row) == 0) || (32'(row) == FbH - 1));
  end
`endif

  // Stage 3: palette read sees the pre-write value when a write hits the same entry.
  always_comb begin
    rgb_d = act2_q ? pal_q[fb_rdata] : 24'h0;
`ifdef BORDER_COLOR_EN
    if (border2_q) begin
      rgb_d = brgb2_q;
    end
`endif
  end

  // Swap only at the start of vertical blank so a frame is never split across buffers.
  always_comb begin
    front_sel_d = front_sel_q;
    swap_ack_d  = 1'b0;
    if (vgaX == 10'd0 && vgaY == VStart && swap_req) begin
      front_sel_d = ~front_sel_q;
      swap_ack_d  = 1'b1;
    end
  end

  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      fb_addr_q   <= '0;
      act1_q      <= 1'b0;
      act2_q      <= 1'b0;
      rgb_q       <= '0;
      hs_q        <= 3'b111;
      vs_q        <= 3'b111;
      bl_q        <= 3'b000;
      sy_q        <= 3'b000;
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      fb_addr_q   <= fb_addr_d;
      act1_q      <= act1_d;
      act2_q      <= act1_q;
      rgb_q       <= rgb_d;
      hs_q        <= {hs_q[1:0], hsync_in};
      vs_q        <= {vs_q[1:0], vsync_in};
      bl_q        <= {bl_q[1:0], blank_b_in};
      sy_q        <= {sy_q[1:0], sync_b_in};
      front_sel_q <= front_sel_d;
      swap_ack_q  <= swap_ack_d;
    end
  end

`ifdef BORDER_COLOR_EN
  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      border1_q <= 1'b0;
      border2_q <= 1'b0;
      brgb1_q   <= '0;
      brgb2_q   <= '0;
    end else begin
      border1_q <= border1_d;
      border2_q <= border1_q;
      brgb1_q   <= border_rgb;
      brgb2_q   <= brgb1_q;
    end
  end
`endif

  // Palette resets to a grey ramp: entry i = i*17 on every channel.
  always_ff @(posedge vgaclk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NPal; i++) begin
        pal_q[i] <= {3{8'(i * 17)}};
      end
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_data;
    end
  end

  assign fb_addr  = fb_addr_q;
  assign swap_ack = swap_ack_q;
  assign back_sel = ~front_sel_q;
  assign r        = rgb_q[23:16];
  assign g        = rgb_q[15:8];
  assign b        = rgb_q[7:0];
  assign hsync    = hs_q[2];
  assign vsync    = vs_q[2];
  assign blank_b  = bl_q[2];
  assign sync_b   = sy_q[2];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed and randomized bench for vga_pixel_fetch against a queue-based reference model
// with a synchronous framebuffer RAM model.
module tb_vga_pixel_fetch;

  logic        vgaclk = 1'b0;
  logic        reset;
  logic [9:0]  vgaX, vgaY;
  logic        hsync_in, vsync_in, blank_b_in, sync_b_in;
  logic [15:0] fb_addr;
  logic [3:0]  fb_rdata;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [23:0] pal_data;
  logic        swap_req, swap_ack, back_sel;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, blank_b, sync_b;

  vga_pixel_fetch dut (
    .vgaclk     (vgaclk),
    .reset      (reset),
    .vgaX       (vgaX),
    .vgaY       (vgaY),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_b_in (blank_b_in),
    .sync_b_in  (sync_b_in),
    .fb_addr    (fb_addr),
    .fb_rdata   (fb_rdata),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_data   (pal_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .back_sel   (back_sel),
    .r          (r),
    .g          (g),
    .b          (b),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank_b    (blank_b),
    .sync_b     (sync_b)
  );

  always #5 vgaclk = ~vgaclk;

  // Framebuffer RAM: data valid one cycle after the address.
  logic [3:0] mem [65536];
  always @(posedge vgaclk) fb_rdata <= mem[fb_addr];

  typedef struct {
    bit          act;
    logic [15:0] addr;
    logic [3:0]  strb;  // {hsync, vsync, blank_b, sync_b}
  } item_t;

  item_t       q[$];
  logic [23:0] pal_m [16];
  bit          front_m;
  bit          ack_m;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_addr(input int x, input int y, input bit f);
    int xc = (x < 640) ? x : 639;
    int yc = (y < 480) ? y : 479;
    return 16'((f ? 19200 : 0) + (yc / 4) * 160 + xc / 4);
  endfunction

  task automatic reset_model();
    item_t rst_it;
    for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};
    front_m = 1'b0;
    ack_m   = 1'b0;
    q.delete();
    rst_it.act  = 1'b0;
    rst_it.addr = '0;
    rst_it.strb = 4'b1100;
    q.push_back(rst_it);
    q.push_back(rst_it);
  endtask

  task automatic drive(input int x, input int y, input logic hs);
    vgaX       = 10'(x);
    vgaY       = 10'(y);
    hsync_in   = hs;
    vsync_in   = 1'b1;
    sync_b_in  = hs;
    blank_b_in = (x < 640) && (y < 480);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rgb"}, {8'h0, r, g, b}, 32'h0);
    chk({tag, "_strb"}, {28'h0, hsync, vsync, blank_b, sync_b}, 32'hC);
    chk({tag, "_addr"}, {16'h0, fb_addr}, 32'h0);
    chk({tag, "_ack"}, {31'h0, swap_ack}, 32'h0);
    chk({tag, "_back"}, {31'h0, back_sel}, 32'h1);
  endtask

  // One pixel clock: record the input, predict what leaves the pipeline, then compare.
  task automatic tick();
    item_t       it, o;
    logic [23:0] exp_rgb;
    bit          sp;
    it.act  = (vgaX < 640) && (vgaY < 480);
    it.addr = model_addr(int'(vgaX), int'(vgaY), front_m);
    it.strb = {hsync_in, vsync_in, blank_b_in, sync_b_in};
    q.push_back(it);
    o       = q.pop_front();
    exp_rgb = o.act ? pal_m[mem[o.addr]] : 24'h0;
    sp      = (vgaX == 10'd0) && (vgaY == 10'd480) && swap_req;
    if (pal_we) pal_m[pal_idx] = pal_data;
    @(posedge vgaclk);
    #1;
    if (sp) front_m = ~front_m;
    ack_m = sp;
    chk("fb_addr", {16'h0, fb_addr}, {16'h0, it.addr});
    chk("addr_range", {31'h0, fb_addr < 16'd38400}, 32'h1);
    chk("rgb", {8'h0, r, g, b}, {8'h0, exp_rgb});
    chk("strobes", {28'h0, hsync, vsync, blank_b, sync_b}, {28'h0, o.strb});
    chk("swap_ack", {31'h0, swap_ack}, {31'h0, ack_m});
    chk("back_sel", {31'h0, back_sel}, {31'h0, ~front_m});
  endtask

  initial begin
    int          px_x, px_y;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = 4'($urandom);
    reset    = 1'b0;
    pal_we   = 1'b0;
    pal_idx  = '0;
    pal_data = '0;
    swap_req = 1'b0;
    drive(700, 500, 1'b1);
    #12;
    check_reset_state("reset");
    @(negedge vgaclk);
    reset = 1'b1;
    reset_model();

    // Pixel (0,0) with index 5 appears as grey 0x55 three cycles later.
    mem[0] = 4'd5;
    drive(0, 0, 1'b1);
    tick();
    chk("addr00", {16'h0, fb_addr}, 32'd0);
    drive(700, 0, 1'b1);
    tick();
    tick();
    chk("pix00_rgb", {8'h0, r, g, b}, 32'h555555);
    chk("pix00_blank", {31'h0, blank_b}, 32'h1);

    drive(7, 9, 1'b1);
    tick();
    chk("addr_7_9", {16'h0, fb_addr}, 32'd321);

    // Swap request held into the swap point.
    swap_req = 1'b1;
    drive(100, 200, 1'b1);
    tick();
    drive(0, 480, 1'b1);
    tick();
    chk("swap_ack_pulse", {31'h0, swap_ack}, 32'h1);
    chk("back_sel_swapped", {31'h0, back_sel}, 32'h0);
    swap_req = 1'b0;
    drive(1, 480, 1'b1);
    tick();
    drive(7, 9, 1'b1);
    tick();
    chk("addr_7_9_swapped", {16'h0, fb_addr}, 32'd19521);

    // Request dropped before the swap point is lost.
    swap_req = 1'b1;
    drive(5, 300, 1'b1);
    tick();
    swap_req = 1'b0;
    drive(0, 480, 1'b1);
    tick();
    chk("no_swap_ack", {31'h0, swap_ack}, 32'h0);
    chk("no_swap_back", {31'h0, back_sel}, 32'h0);

    // Palette write on the cycle index 5 is read: old colour now, new colour afterwards.
    a = model_addr(40, 40, 1'b1);
    mem[a] = 4'd5;
    drive(40, 40, 1'b1);
    tick();
    drive(700, 10, 1'b1);
    tick();
    pal_we   = 1'b1;
    pal_idx  = 4'd5;
    pal_data = 24'hFF0000;
    drive(700, 11, 1'b1);
    tick();
    pal_we = 1'b0;
    chk("pal_old_value", {8'h0, r, g, b}, 32'h555555);
    drive(40, 40, 1'b1);
    tick();
    drive(700, 12, 1'b1);
    tick();
    tick();
    chk("pal_new_value", {8'h0, r, g, b}, 32'hFF0000);

    // Blanked pixel maps to black; an hsync pulse of width 3 is reproduced by the model checks.
    a = model_addr(700, 20, 1'b1);
    mem[a] = 4'hF;
    drive(700, 20, 1'b1);
    tick();
    drive(701, 20, 1'b0);
    tick();
    drive(702, 20, 1'b0);
    tick();
    chk("blank_black", {8'h0, r, g, b}, 32'h0);
    drive(703, 20, 1'b0);
    tick();
    chk("hsync_low", {31'h0, hsync}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(704 + i, 20, 1'b1);
      tick();
    end

    // Randomized traffic, with the swap point visited regularly.
    for (int n = 0; n < 3000; n++) begin
      if (n % 97 == 0) begin
        px_x = 0;
        px_y = 480;
      end else if ($urandom_range(0, 3) == 0) begin
        px_x = int'($urandom_range(0, 1023));
        px_y = int'($urandom_range(0, 1023));
      end else begin
        px_x = int'($urandom_range(0, 639));
        px_y = int'($urandom_range(0, 479));
      end
      drive(px_x, px_y, 1'($urandom));
      vsync_in   = 1'($urandom);
      blank_b_in = 1'($urandom);
      swap_req   = 1'($urandom);
      pal_we     = ($urandom_range(0, 7) == 0);
      pal_idx    = 4'($urandom);
      pal_data   = 24'($urandom);
      tick();
    end
    pal_we = 1'b0;

    // Reset mid-line with a pending swap and a modified palette.
    pal_we   = 1'b1;
    pal_idx  = 4'd5;
    pal_data = 24'h123456;
    drive(300, 100, 1'b1);
    tick();
    pal_we   = 1'b0;
    swap_req = 1'b1;
    drive(301, 100, 1'b1);
    @(negedge vgaclk);
    reset = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge vgaclk);
    check_reset_state("midreset_held");
    reset = 1'b1;
    reset_model();
    a = model_addr(20, 30, 1'b0);
    mem[a] = 4'd5;
    drive(20, 30, 1'b1);
    tick();
    drive(21, 30, 1'b1);
    tick();
    drive(22, 30, 1'b1);
    tick();
    chk("post_reset_pal5", {8'h0, r, g, b}, 32'h555555);
    chk("post_reset_back", {31'h0, back_sel}, 32'h1);
    chk("post_reset_ack", {31'h0, swap_ack}, 32'h0);
    swap_req = 1'b0;
    drive(23, 30, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Sits directly downstream of the VGA timing block in the vgaclk domain.
- Consumes its pixel coordinates and sync/blank strobes.
- Fetches palette indices from an external double-buffered framebuffer RAM, scales a 160x120 image to 640x480, and maps indices through a writable 16-entry palette to 24-bit RGB.
- Delays the sync/blank strobes so they stay aligned with the RGB output. Performs tear-free front/back buffer swaps on request.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SCALE_SHIFT, 2, log2 of the upscale factor; FB_W = H_ACTIVE>>SCALE_SHIFT, FB_H = V_ACTIVE>>SCALE_SHIFT
- IDX_W, 4, palette index width (2**IDX_W palette entries)
- ADDR_W, 16, framebuffer address width (must hold 2*FB_W*FB_H)

Ports:
- vgaclk  in  1  pixel clock, the only clock
- reset  in  1  asynchronous, active-low reset
- vgaX  in  10  current pixel column from the timing block
- vgaY  in  10  current pixel row from the timing block
- hsync_in  in  1  hsync from the timing block
- vsync_in  in  1  vsync from the timing block
- blank_b_in  in  1  active-video flag from the timing block
- sync_b_in  in  1  composite sync from the timing block
- fb_addr  out  ADDR_W  framebuffer read address
- fb_rdata  in  IDX_W  framebuffer read data; synchronous RAM, valid 1 cycle after fb_addr
- pal_we  in  1  palette write enable
- pal_idx  in  IDX_W  palette entry to write
- pal_data  in  24  palette write data {r,g,b}
- swap_req  in  1  writer requests a buffer swap (level)
- swap_ack  out  1  one-cycle pulse when the swap has taken effect
- back_sel  out  1  buffer the writer may draw into (~front_sel)
- r, g, b  out  8 each  to the video DAC
- hsync, vsync, blank_b, sync_b  out  1 each  delayed strobes to the monitor/DAC

Behaviour:
- Pipeline latency is exactly 3 vgaclk cycles from vgaX/vgaY/strobes to r/g/b and the delayed strobes.
- Stage 1 registers fb_addr = front_sel*FB_W*FB_H + (vgaY>>SCALE_SHIFT)*FB_W + (vgaX>>SCALE_SHIFT).
  - Arithmetic is unsigned, truncated to ADDR_W.
  - Also registers act1 = (vgaX < H_ACTIVE) && (vgaY < V_ACTIVE).
- Stage 2: the RAM returns fb_rdata; act2 is registered.
- Stage 3: r/g/b = palette[fb_rdata] when act2, else 0, registered.
- Strobe alignment: hsync/vsync/blank_b/sync_b each pass through a 3-deep shift register.
- Outside the active area, fb_addr holds the value computed from the clamped coordinates. Its content is don't-care, but it must never exceed 2*FB_W*FB_H-1.
- Palette:
  - 2**IDX_W x 24 register array.
  - Reset value of entry i = {i*17, i*17, i*17} (grey ramp for IDX_W=4).
  - A write occurs on the cycle pal_we=1.
  - A same-cycle read of the entry being written returns the old value; the new value is visible from the next cycle.
- Swap:
  - front_sel resets to 0.
  - The swap point is the cycle with vgaX==0 && vgaY==V_ACTIVE (start of vertical blank).
  - If swap_req==1 at the swap point: front_sel toggles and swap_ack=1 on the next cycle, for exactly one cycle.
  - If swap_req==0 at the swap point, nothing happens. A request dropped before the swap point is lost.
  - The writer holds swap_req until it sees swap_ack, then drops it. If it is still high at the next swap point, a second swap occurs.
  - back_sel changes only at the swap.
- Reset (asynchronous assert, held during operation):
  - Pipeline, fb_addr, r/g/b and swap_ack go to 0.
  - hsync/vsync go to 1 (inactive; the timing block drives active-low syncs).
  - blank_b and sync_b go to 0.
  - front_sel goes to 0 and the palette returns to the grey ramp.
  - Release takes effect on the first vgaclk edge after deassertion; no partial frame state is retained.

Optional Feature:
- BORDER_COLOR_EN: adds input border_rgb[23:0].
- When defined:
  - Pixels inside the active area whose scaled column is 0 or FB_W-1, or whose scaled row is 0 or FB_H-1, output border_rgb instead of the palette colour.
  - Border pixels keep the same 3-cycle latency.
  - border_rgb is sampled at stage 1.
- When undefined: the port is absent and all active pixels use the palette.

Test Plan:
- Reset, then pixel (0,0) with fb_rdata=5 and blank_b_in=1 -> fb_addr=0 after 1 cycle; r=g=b=0x55 and blank_b=1 exactly 3 cycles after input.
- vgaX=7, vgaY=9, front_sel=0 -> fb_addr=2*160+1=321; after one swap, same coordinates -> fb_addr=19521.
- swap_req=1 held across the frame -> swap_ack pulses once, on the cycle after (0,480); back_sel goes 1->0; swap_req dropped at vgaY=300 -> no swap, no ack.
- pal_we=1, pal_idx=5, pal_data=0xFF0000 on the same cycle that index 5 reaches stage 3 -> old grey 0x555555 output; the next index-5 pixel outputs r=0xFF, g=b=0.
- vgaX=700 (in blank) with fb_rdata=0xF -> r=g=b=0 after 3 cycles; hsync_in pulse is reproduced on hsync 3 cycles later with identical width.
- Reset asserted mid-line with swap pending and palette modified -> outputs go to their reset values immediately; after release, front_sel=0, swap_ack stays 0 and palette entry 5 reads 0x555555.
